// File: rtl/offchip_arbiter.sv
// Arbitrates NUM_CH cache refill requesters onto one off-chip line port,
// optionally writing back the winner's dirty victim line before the refill read.
module offchip_arbiter #(
  parameter int unsigned NUM_CH     = 32'd2,
  parameter int unsigned ADDR_W     = 32'd32,
  parameter int unsigned LINE_BYTES = 32'd16,
  parameter int unsigned ARB_MODE   = 32'd1,
  localparam int unsigned LINE_W    = LINE_BYTES * 32'd8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wb,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_wb_addr,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wb_data,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          offchip_mem_addr,
  output logic                       offchip_mem_read_en,
  output logic                       offchip_mem_write_en,
  output logic [LINE_W-1:0]          offchip_mem_wdata,
  input  logic [LINE_W-1:0]          offchip_mem_data,
  input  logic                       offchip_mem_ready
);

  localparam int unsigned IDX_W = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_RD   = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                read_en_q, read_en_d;
  logic                write_en_q, write_en_d;
  logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
  logic                busy_q, busy_d;
  logic                armed_q, armed_d;

  logic [IDX_W-1:0]    grant_idx;
  logic [31:0]         arb_raw;
  logic [31:0]         arb_dist;
  logic [31:0]         arb_best;
  logic                arb_take;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   sel_wb_addr;
  logic [LINE_W-1:0]   sel_wb_data;
  logic                sel_wb;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_BYTES - 32'd1);
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  // Winner search: smallest distance past last_q (round-robin) or smallest index (fixed).
  always_comb begin
    grant_idx = '0;
    arb_best  = NUM_CH;
    arb_raw   = 32'd0;
    arb_dist  = 32'd0;
    arb_take  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 32'd0) begin
        arb_dist = i;
      end else begin
        arb_raw  = i + NUM_CH - 32'd1 - 32'(last_q);
        arb_dist = (arb_raw >= NUM_CH) ? (arb_raw - NUM_CH) : arb_raw;
      end
      arb_take  = ch_req[i] && (arb_dist < arb_best);
      arb_best  = arb_take ? arb_dist : arb_best;
      grant_idx = arb_take ? IDX_W'(i) : grant_idx;
    end
  end

  // Steer the winning channel's request fields towards the grant latches.
  always_comb begin
    sel_addr    = '0;
    sel_wb_addr = '0;
    sel_wb_data = '0;
    sel_wb      = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_addr    = (grant_idx == IDX_W'(i)) ? ch_addr[i*ADDR_W +: ADDR_W]    : sel_addr;
      sel_wb_addr = (grant_idx == IDX_W'(i)) ? ch_wb_addr[i*ADDR_W +: ADDR_W] : sel_wb_addr;
      sel_wb_data = (grant_idx == IDX_W'(i)) ? ch_wb_data[i*LINE_W +: LINE_W] : sel_wb_data;
      sel_wb      = (grant_idx == IDX_W'(i)) ? ch_wb[i]                       : sel_wb;
    end
  end

  // Transaction sequencing; strobes are computed one state ahead so they leave a flop.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    raddr_d    = raddr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    read_en_d  = read_en_q;
    write_en_d = write_en_q;
    ch_done_d  = '0;
    armed_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        // armed_q keeps the first edge after reset release from granting.
        if (armed_q && (|ch_req)) begin
          win_d   = grant_idx;
          raddr_d = line_align(sel_addr);
          if (sel_wb) begin
            state_d    = S_WB;
            write_en_d = 1'b1;
            addr_d     = line_align(sel_wb_addr);
            wdata_d    = sel_wb_data;
          end else begin
            state_d   = S_RD;
            read_en_d = 1'b1;
            addr_d    = line_align(sel_addr);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        read_en_d = 1'b0;
        if (write_en_q && offchip_mem_ready) begin
          write_en_d = 1'b0;
          addr_d     = raddr_q;
          state_d    = S_RD;
        end else begin
          write_en_d = 1'b1;
        end
      end
      S_RD: begin
        write_en_d = 1'b0;
        // Arriving from WB, read_en_q is still low: one dead cycle between strobes.
        if (read_en_q && offchip_mem_ready) begin
          rdata_d   = offchip_mem_data;
          read_en_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          read_en_d = 1'b1;
        end
      end
      S_DONE: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        ch_done_d  = ch_onehot(win_q);
        last_d     = win_q;
        state_d    = S_GAP;
      end
      S_GAP: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      last_q     <= IDX_W'(NUM_CH - 32'd1);
      raddr_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      ch_done_q  <= '0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      raddr_q    <= raddr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      read_en_q  <= read_en_d;
      write_en_q <= write_en_d;
      ch_done_q  <= ch_done_d;
      busy_q     <= busy_d;
      armed_q    <= armed_d;
    end
  end

  assign ch_done              = ch_done_q;
  assign ch_rdata             = rdata_q;
  assign busy                 = busy_q;
  assign offchip_mem_addr     = addr_q;
  assign offchip_mem_read_en  = read_en_q;
  assign offchip_mem_write_en = write_en_q;
  assign offchip_mem_wdata    = wdata_q;

endmodule

// File: doc/offchip_arbiter.md
OFFCHIP_ARBITER -- requirements
Module: offchip_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of cache requester channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-003 SHALL have parameter LINE_BYTES, default 16, meaning the cache line size in bytes, a power of two; LINE_W = LINE_BYTES*8.
REQ-004 SHALL have parameter ARB_MODE, default 1, meaning 0 = fixed priority (lowest index wins) and 1 = round-robin.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports clk and rst.
REQ-006 SHALL have ports, each given as name  direction  width  meaning:
  clk  in  1  clock, rising edge
  rst  in  1  asynchronous active-low reset
  ch_req  in  NUM_CH  per-channel line-refill request, level
  ch_wb  in  NUM_CH  per-channel dirty victim present: write back before refill
  ch_addr  in  NUM_CH*ADDR_W  per-channel refill address, channel i at bits [i*ADDR_W +: ADDR_W]
  ch_wb_addr  in  NUM_CH*ADDR_W  per-channel victim address
  ch_wb_data  in  NUM_CH*LINE_W  per-channel victim line data
  ch_done  out  NUM_CH  one-cycle pulse on the owning channel when its refill data is valid
  ch_rdata  out  LINE_W  refill line, shared by all channels, valid in the ch_done cycle
  busy  out  1  transaction in progress
  offchip_mem_addr  out  ADDR_W  line-aligned off-chip address
  offchip_mem_read_en  out  1  off-chip read strobe, level
  offchip_mem_write_en  out  1  off-chip write strobe, level
  offchip_mem_wdata  out  LINE_W  write-back line data
  offchip_mem_data  in  LINE_W  off-chip read data
  offchip_mem_ready  in  1  off-chip completion, sampled while a strobe is high

Function
REQ-007 SHALL implement the states IDLE, WB, RD, DONE and GAP, all registered.
REQ-008 In IDLE with any ch_req high, SHALL latch the winner index, its address, ch_wb bit and victim data, then go to WB if ch_wb=1, else RD.
REQ-009 In IDLE with no request, SHALL stay in IDLE and hold both strobes low.
REQ-010 In fixed priority mode, SHALL grant the lowest set index.
REQ-011 In round-robin mode, SHALL search from last_grant+1 modulo NUM_CH, wrapping from NUM_CH-1 to 0; last_grant SHALL reset to NUM_CH-1, so channel 0 wins first.
REQ-012 In WB, SHALL drive offchip_mem_addr = latched victim address with its low log2(LINE_BYTES) bits zeroed, hold offchip_mem_wdata at the latched victim data, and hold offchip_mem_write_en=1.
REQ-013 SHALL leave WB on the first cycle offchip_mem_ready=1 is sampled: deassert write_en and enter RD on the next cycle.
REQ-014 In RD, SHALL drive the aligned refill address, hold offchip_mem_read_en=1, and on offchip_mem_ready=1 capture offchip_mem_data into ch_rdata, deassert read_en and enter DONE.
REQ-015 read_en and write_en SHALL never be high in the same cycle.
REQ-016 In DONE, SHALL pulse ch_done[winner] for exactly one cycle with ch_rdata valid, update last_grant, then enter GAP.
REQ-017 GAP SHALL last one cycle before returning to IDLE, so the requester deasserts ch_req before re-arbitration.
REQ-018 Latency without write-back SHALL be request sampled in IDLE -> read_en high next cycle -> ch_done 2 cycles after ready is sampled.
REQ-019 With write-back, latency SHALL additionally include the WB wait plus one cycle.
REQ-020 Requester inputs SHALL be captured at grant, so input changes after grant SHALL be ignored.
REQ-021 If ch_req drops mid-transaction, the transaction SHALL still complete and ch_done SHALL still pulse.
REQ-022 A requester that keeps ch_req high after its done SHALL be treated as a new request in the next IDLE.
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 ch_rdata SHALL hold its value until the next capture.

Reset
REQ-025 When rst=0, SHALL asynchronously force state=IDLE, read_en=0, write_en=0, ch_done=0, busy=0, last_grant=NUM_CH-1, offchip_mem_addr=0, offchip_mem_wdata=0 and ch_rdata=0.
REQ-026 Reset asserted mid-transaction SHALL abort that transaction with no ch_done pulse, and SHALL drop the strobes within the reset cycle.
REQ-027 After rst rises, the first grant SHALL be no earlier than the second rising edge.

Verification
REQ-028 Single read: NUM_CH=2, ch_req=01, ch_wb=0, ch_addr0=0x1234, ready after 3 cycles -> offchip_mem_addr=0x1230 with read_en for 3 cycles, then ch_done=01 with ch_rdata equal to the driven data.
REQ-029 Write-back then refill: ch_wb0=1, wb_addr=0x8008, addr=0x4004 -> write_en with addr 0x8000 and victim data, then read_en with 0x4000, then a single done pulse; strobes never overlap.
REQ-030 Round-robin: NUM_CH=4, ch_req=1111 held continuously -> done order 0,1,2,3,0 (wrap), exactly one done per transaction.
REQ-031 Fixed priority: ARB_MODE=0, ch_req=1010 held -> channel 1 is served repeatedly and channel 3 is never granted while channel 1 is requesting.
REQ-032 Reset mid-RD: rst=0 while read_en=1 -> read_en=0 immediately and no ch_done; after release, a pending ch_req=0001 is served normally.
REQ-033 Early request drop: ch_req0 deasserted one cycle after grant -> the transaction completes, ch_done0 pulses, and no second transaction starts.
